// File: rtl/mac_frame_accumulator.sv
// Frame accumulator: sums FRAME_LEN accepted products and hands each frame sum out via a valid/ready register.
// Build option: define MAC_ACC_SATURATE_EN to clamp the running sum on overflow instead of wrapping.
module mac_frame_accumulator #(
  parameter int IN_W      = 16,
  parameter int ACC_W     = 24,
  parameter int FRAME_LEN = 8,
  parameter int SIGNED    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IN_W-1:0]                  in_data,
  input  logic                             clear,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 acc_out,
  output logic                             out_ovf,
  output logic [$clog2(FRAME_LEN+1)-1:0]   count
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t           state_reg;
  logic [ACC_W-1:0] acc_reg;
  logic             fovf_reg;

  logic [ACC_W-1:0] ext_data;
  logic [ACC_W-1:0] base;
  logic [ACC_W:0]   sum_full;
  logic [ACC_W-1:0] sum_wrap;
  logic [ACC_W-1:0] acc_next;
  logic             carry_msb;
  logic             add_ovf;
  logic             accept;
  logic             last;

  generate
    if (ACC_W > IN_W) begin : g_ext
      if (SIGNED != 0) begin : g_sext
        assign ext_data = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
      end else begin : g_zext
        assign ext_data = {{(ACC_W-IN_W){1'b0}}, in_data};
      end
    end else begin : g_noext
      assign ext_data = in_data;
    end
  endgenerate

  // A frame's first sample loads rather than adds, so the stale sum never leaks in.
  assign base      = (state_reg == IDLE) ? '0 : acc_reg;
  assign sum_full  = {1'b0, base} + {1'b0, ext_data};
  assign sum_wrap  = sum_full[ACC_W-1:0];
  assign carry_msb = sum_wrap[ACC_W-1] ^ base[ACC_W-1] ^ ext_data[ACC_W-1];

  generate
    if (SIGNED != 0) begin : g_sovf
      // Two's-complement overflow: carry into the sign bit differs from carry out of it.
      assign add_ovf = sum_full[ACC_W] ^ carry_msb;
    end else begin : g_uovf
      assign add_ovf = sum_full[ACC_W] & (carry_msb | ~carry_msb);
    end
  endgenerate

`ifdef MAC_ACC_SATURATE_EN
  logic [ACC_W-1:0] sat_val;
  generate
    if (SIGNED != 0) begin : g_ssat
      // Both operands share a sign on overflow, so base's sign gives the direction.
      assign sat_val = base[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin : g_usat
      assign sat_val = '1;
    end
  endgenerate
  assign acc_next = add_ovf ? sat_val : sum_wrap;
`else
  assign acc_next = sum_wrap;
`endif

  // Only registered state feeds in_ready, keeping out_ready off the input path.
  assign in_ready = !(out_valid && (count == LAST_CNT));
  assign accept   = in_valid & in_ready & ~clear;
  assign last     = accept && (count == LAST_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      fovf_reg  <= 1'b0;
      count     <= '0;
      acc_out   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (last) begin
        out_valid <= 1'b1;
        acc_out   <= acc_next;
        out_ovf   <= fovf_reg | add_ovf;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (clear) begin
        state_reg <= IDLE;
        acc_reg   <= '0;
        fovf_reg  <= 1'b0;
        count     <= '0;
      end else if (accept) begin
        acc_reg <= acc_next;
        if (last) begin
          state_reg <= IDLE;
          fovf_reg  <= 1'b0;
          count     <= '0;
        end else begin
          state_reg <= ACCUM;
          fovf_reg  <= fovf_reg | add_ovf;
          count     <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_accumulator.sv
// Bench: five accumulator configurations share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_mac_frame_accumulator;

  localparam int NCFG = 5;

  function automatic int cfg_aw(input int i);
    case (i)
      0: return 24;
      1: return 24;
      default: return 16;
    endcase
  endfunction

  function automatic int cfg_fl(input int i);
    case (i)
      0: return 4;
      1: return 4;
      2: return 2;
      3: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_sg(input int i);
    case (i)
      1: return 1;
      3: return 1;
      4: return 1;
      default: return 0;
    endcase
  endfunction

  typedef struct {
    int     cnt;
    longint acc;
    bit     fovf;
    bit     ov;
    longint out;
    bit     oovf;
  } mstate_t;

  // Next model state from the arithmetic meaning of a frame: true sum, range check, wrap or clamp.
  function automatic mstate_t step(input mstate_t s, input int aw, input int fl, input bit sg,
                                   input logic r, input logic iv, input logic [15:0] d,
                                   input logic clr, input logic ordy);
    mstate_t n;
    longint one, lo, hi, span, x, cur, t;
    bit rdy, ovf, f;
    n = s;
    if (r) begin
      n = '{default: 0};
      return n;
    end
    one  = 1;
    span = one << aw;
    hi   = sg ? (one << (aw - 1)) - 1 : span - 1;
    lo   = sg ? -(one << (aw - 1)) : 0;
    rdy  = !(s.ov && s.cnt == fl - 1);
    if (s.ov && ordy) n.ov = 0;
    if (clr) begin
      n.cnt = 0; n.acc = 0; n.fovf = 0;
      return n;
    end
    if (iv && rdy) begin
      x   = sg ? longint'($signed(d)) : longint'({48'd0, d});
      cur = (s.cnt == 0) ? 0 : s.acc;
      t   = cur + x;
      ovf = (t < lo) || (t > hi);
      if (ovf) begin
`ifdef MAC_ACC_SATURATE_EN
        t = (t > hi) ? hi : lo;
`else
        t = t & (span - 1);
        if (sg && t > hi) t = t - span;
`endif
      end
      f = ((s.cnt == 0) ? 1'b0 : s.fovf) | ovf;
      if (s.cnt + 1 == fl) begin
        n.ov = 1; n.out = t & (span - 1); n.oovf = f;
        n.cnt = 0; n.acc = 0; n.fovf = 0;
      end else begin
        n.cnt = s.cnt + 1; n.acc = t; n.fovf = f;
      end
    end
    return n;
  endfunction

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        clear;
  logic        out_ready;
  logic        chk_en;
  int          pin_id;
  int          n_tests;
  int          n_fail;

  logic        d_rdy [NCFG];
  logic        d_vld [NCFG];
  logic        d_ovf [NCFG];
  logic [63:0] d_acc [NCFG];
  logic [31:0] d_cnt [NCFG];
  logic        m_ov  [NCFG];
  logic        m_oovf[NCFG];
  logic [63:0] m_out [NCFG];
  logic [31:0] m_cnt [NCFG];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NCFG; gi++) begin : g
    localparam int AW = cfg_aw(gi);
    localparam int FL = cfg_fl(gi);
    localparam int SG = cfg_sg(gi);
    localparam int CW = $clog2(FL + 1);

    logic          in_ready;
    logic          out_valid;
    logic          out_ovf;
    logic [AW-1:0] acc_out;
    logic [CW-1:0] count;
    mstate_t       m;

    mac_frame_accumulator #(.IN_W(16), .ACC_W(AW), .FRAME_LEN(FL), .SIGNED(SG)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .clear(clear), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out),
      .out_ovf(out_ovf), .count(count)
    );

    always @(posedge clk) m <= step(m, AW, FL, SG != 0, rst, in_valid, in_data, clear, out_ready);

    assign d_rdy[gi]  = in_ready;
    assign d_vld[gi]  = out_valid;
    assign d_ovf[gi]  = out_ovf;
    assign d_acc[gi]  = 64'(acc_out);
    assign d_cnt[gi]  = 32'(count);
    assign m_ov[gi]   = m.ov;
    assign m_oovf[gi] = m.oovf;
    assign m_out[gi]  = m.out;
    assign m_cnt[gi]  = 32'(m.cnt);
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

`ifdef MAC_ACC_SATURATE_EN
  localparam longint OVF_U = 64'hFFFF;
  localparam longint OVF_S = 64'h7FFF;
`else
  localparam longint OVF_U = 64'h0001;
  localparam longint OVF_S = 64'hFFFF;
`endif

  // Single compare process: model check for every configuration, then any pinned literal checks.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < NCFG; i++) begin
        chk($sformatf("cfg%0d.out_valid", i), longint'(d_vld[i]), longint'(m_ov[i]));
        chk($sformatf("cfg%0d.acc_out", i), longint'(d_acc[i]), longint'(m_out[i]));
        chk($sformatf("cfg%0d.out_ovf", i), longint'(d_ovf[i]), longint'(m_oovf[i]));
        chk($sformatf("cfg%0d.count", i), longint'(d_cnt[i]), longint'(m_cnt[i]));
        chk($sformatf("cfg%0d.in_ready", i), longint'(d_rdy[i]),
            longint'(!(m_ov[i] && m_cnt[i] == 32'(cfg_fl(i) - 1))));
        if (d_vld[i] && out_ready)
          $display("[TB] cfg%0d result acc_out=%0h out_ovf=%0d", i, d_acc[i], d_ovf[i]);
      end
      case (pin_id)
        1: begin
          chk("pin.reset.out_valid", longint'(d_vld[0]), 0);
          chk("pin.reset.acc_out", longint'(d_acc[0]), 0);
          chk("pin.reset.count", longint'(d_cnt[0]), 0);
          chk("pin.reset.in_ready", longint'(d_rdy[0]), 1);
        end
        2: begin
          chk("pin.usum.out_valid", longint'(d_vld[0]), 1);
          chk("pin.usum.acc_out", longint'(d_acc[0]), 10);
          chk("pin.usum.model", longint'(m_out[0]), 10);
          chk("pin.usum.out_ovf", longint'(d_ovf[0]), 0);
        end
        3: chk("pin.usum.one_cycle", longint'(d_vld[0]), 0);
        4: begin
          chk("pin.ssum.acc_out", longint'(d_acc[1]), 64'hFFFFF9);
          chk("pin.ssum.model", longint'(m_out[1]), 64'hFFFFF9);
          chk("pin.ssum.out_ovf", longint'(d_ovf[1]), 0);
          chk("pin.ssum.out_valid", longint'(d_vld[1]), 1);
        end
        5: begin
          chk("pin.fl1.out_valid", longint'(d_vld[3]), 1);
          chk("pin.fl1.acc_out", longint'(d_acc[3]), 64'hFFFB);
          chk("pin.fl1.out_ovf", longint'(d_ovf[3]), 0);
        end
        6: begin
          chk("pin.bp.first.out_valid", longint'(d_vld[2]), 1);
          chk("pin.bp.first.acc_out", longint'(d_acc[2]), 11);
        end
        7: begin
          chk("pin.bp.hold.count", longint'(d_cnt[2]), 1);
          chk("pin.bp.hold.in_ready", longint'(d_rdy[2]), 0);
          chk("pin.bp.hold.acc_out", longint'(d_acc[2]), 11);
        end
        8: begin
          chk("pin.bp.drain.out_valid", longint'(d_vld[2]), 0);
          chk("pin.bp.drain.in_ready", longint'(d_rdy[2]), 1);
        end
        9: begin
          chk("pin.bp.second.out_valid", longint'(d_vld[2]), 1);
          chk("pin.bp.second.acc_out", longint'(d_acc[2]), 15);
        end
        10: begin
          chk("pin.uovf.out_ovf", longint'(d_ovf[2]), 1);
          chk("pin.uovf.acc_out", longint'(d_acc[2]), OVF_U);
          chk("pin.uovf.model", longint'(m_out[2]), OVF_U);
        end
        11: begin
          chk("pin.sovf.out_ovf", longint'(d_ovf[4]), 1);
          chk("pin.sovf.acc_out", longint'(d_acc[4]), OVF_S);
        end
        12: chk("pin.clear.count", longint'(d_cnt[0]), 0);
        13: begin
          chk("pin.clear.acc_out", longint'(d_acc[0]), 4);
          chk("pin.clear.out_valid", longint'(d_vld[0]), 1);
          chk("pin.clear.out_ovf", longint'(d_ovf[0]), 0);
        end
        14: begin
          chk("pin.rstmid.out_valid", longint'(d_vld[2]), 0);
          chk("pin.rstmid.acc_out", longint'(d_acc[2]), 0);
          chk("pin.rstmid.count", longint'(d_cnt[2]), 0);
          chk("pin.rstmid.in_ready", longint'(d_rdy[2]), 1);
        end
        default: ;
      endcase
    end
  end

  // One stimulus cycle; pin selects literal checks for the state left by the previous cycle.
  task automatic cyc(input logic r, input logic iv, input logic [15:0] d,
                     input logic c, input logic o, input int p);
    @(posedge clk);
    #2;
    rst = r; in_valid = iv; in_data = d; clear = c; out_ready = o; pin_id = p;
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 0);
  endtask

  initial begin
    logic [15:0] picks [5];
    logic [15:0] dv;
    picks = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    rst = 1'b1; in_valid = 1'b0; in_data = '0; clear = 1'b0; out_ready = 1'b0;
    chk_en = 1'b0; pin_id = 0; n_tests = 0; n_fail = 0;

    do_reset();
    chk_en = 1'b1;
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1);

    // unsigned sum 1..4
    do_reset();
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd3, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd4, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 2);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 3);

    // signed sum -5,3,-7,2
    do_reset();
    cyc(1'b0, 1'b1, 16'hFFFB, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'h0003, 1'b0, 1'b1, 5);
    cyc(1'b0, 1'b1, 16'hFFF9, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 4);

    // backpressure on the two-sample frame
    do_reset();
    cyc(1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 16'd6, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 16'd7, 1'b0, 1'b0, 6);
    cyc(1'b0, 1'b1, 16'd8, 1'b0, 1'b0, 7);
    cyc(1'b0, 1'b1, 16'd8, 1'b0, 1'b1, 7);
    cyc(1'b0, 1'b1, 16'd8, 1'b0, 1'b0, 8);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 9);

    // unsigned overflow
    do_reset();
    cyc(1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'h0002, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 10);

    // signed overflow on the three-sample frame
    do_reset();
    cyc(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'h0001, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 11);

    // clear mid-frame drops the offered sample
    do_reset();
    cyc(1'b0, 1'b1, 16'd9, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd9, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd9, 1'b1, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 12);
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 13);

    // reset with a pending result and a partial frame
    do_reset();
    cyc(1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 16'd2, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 14);

    // randomized traffic
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) dv = picks[$urandom_range(0, 4)];
      else dv = 16'($urandom);
      cyc(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 9) < 7), dv,
          1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), 0);
    end
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 0);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
